pc_gen: RTL and testbench

- Sequential fetch-address generator for the pipelined MIPS core, in the F stage.
- Replaces the single-cycle next-PC logic with a registered PC that adds stall hold, a pending-redirect buffer, exception entry, ERET return and fetch-address checking.
- Redirect targets are computed from the PC of the redirecting instruction (D stage), not from the current fetch PC.
- Reset/exception vectors and instruction-memory bounds are parameters.

---
 rtl/pc_gen.sv | 119 +++++++++++
 tb/tb_pc_gen.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// pc_gen: registered fetch-address generator for the F stage of the pipelined core.
// It holds the PC during a stall and buffers one pending redirect until the stall
// ends. It also handles exception entry and eret return, and flags illegal fetch
// addresses.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous reset, active-low
//   stall          hold F stage
//   br_taken       conditional branch in D resolved taken
//   br_offset      sign-extended branch immediate (word offset)
//   j_en, j_index  j/jal in D and its 26-bit index
//   jr_en, jr_addr jr/jalr in D and its forwarded rs value
//   d_pc           PC of the instruction in D (base for branch/jump targets)
//   exc_req        take exception, vector to EXC_VECTOR
//   eret_req, epc  eret committing and its return address
//   pc             current fetch address (register)
//   pc_adel        fetch address misaligned or outside [IMEM_LO, IMEM_HI]
//   redirect_lost  one-cycle pulse: a fresh redirect was dropped while draining a pending one
module pc_gen #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [31:0] IMEM_LO    = 32'h0000_3000,
    parameter logic [31:0] IMEM_HI    = 32'h0000_6ffc
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_offset,
    input  logic        j_en,
    input  logic [25:0] j_index,
    input  logic        jr_en,
    input  logic [31:0] jr_addr,
    input  logic [31:0] d_pc,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] pc,
    output logic        pc_adel,
    output logic        redirect_lost
);

    logic        pendValid;
    logic [31:0] pendAddr;

    logic [31:0] dPcPlus4;
    logic [31:0] brTarget;
    logic [31:0] jTarget;
    logic        redir;
    logic [31:0] redirAddr;

    logic [31:0] pcNext;
    logic        pendValidNext;
    logic [31:0] pendAddrNext;
    logic        redirectLostNext;

    // Targets are relative to the redirecting instruction in D, not the fetch PC.
    assign dPcPlus4 = d_pc + 32'd4;
    assign brTarget = dPcPlus4 + {br_offset[29:0], 2'b00};
    assign jTarget  = {dPcPlus4[31:28], j_index, 2'b00};
    assign redir    = jr_en | j_en | br_taken;

    always_comb begin
        redirAddr = brTarget;
        if (jr_en) begin
            redirAddr = jr_addr;
        end else if (j_en) begin
            redirAddr = jTarget;
        end
    end

    always_comb begin
        pcNext           = pc + 32'd4;
        pendValidNext    = pendValid;
        pendAddrNext     = pendAddr;
        redirectLostNext = 1'b0;
        if (exc_req) begin
            pcNext        = EXC_VECTOR;
            pendValidNext = 1'b0;
        end else if (eret_req) begin
            pcNext        = epc;
            pendValidNext = 1'b0;
        end else if (stall) begin
            pcNext = pc;
            if (redir) begin
                // Newest redirect wins; an older buffered one is overwritten.
                pendAddrNext  = redirAddr;
                pendValidNext = 1'b1;
            end
        end else if (pendValid) begin
            // The buffered redirect is older, so it takes this slot and any
            // simultaneous fresh redirect is dropped and reported.
            pcNext           = pendAddr;
            pendValidNext    = 1'b0;
            redirectLostNext = redir;
        end else if (redir) begin
            pcNext = redirAddr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc            <= RESET_PC;
            pendValid     <= 1'b0;
            pendAddr      <= 32'h0;
            redirect_lost <= 1'b0;
        end else begin
            pc            <= pcNext;
            pendValid     <= pendValidNext;
            pendAddr      <= pendAddrNext;
            redirect_lost <= redirectLostNext;
        end
    end

    // The core keeps fetching from a bad address; CP0 decides what to do with it.
    assign pc_adel = (pc[1:0] != 2'b00) | (pc < IMEM_LO) | (pc > IMEM_HI);

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_offset;
    logic        j_en;
    logic [25:0] j_index;
    logic        jr_en;
    logic [31:0] jr_addr;
    logic [31:0] d_pc;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic [31:0] pc;
    logic        pc_adel;
    logic        redirect_lost;

    typedef struct packed {
        logic [31:0] pc;
        logic        lost;
        logic        adel;
    } exp_t;

    exp_t  expQ[$];
    string tagQ[$];
    int    checks = 0;
    int    errors = 0;

    pc_gen dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .br_taken     (br_taken),
        .br_offset    (br_offset),
        .j_en         (j_en),
        .j_index      (j_index),
        .jr_en        (jr_en),
        .jr_addr      (jr_addr),
        .d_pc         (d_pc),
        .exc_req      (exc_req),
        .eret_req     (eret_req),
        .epc          (epc),
        .pc           (pc),
        .pc_adel      (pc_adel),
        .redirect_lost(redirect_lost)
    );

    always #5 clk = ~clk;

    // Expected state after the next rising edge.
    task automatic expect_next(input string tag, input logic [31:0] ePc,
                               input logic eLost, input logic eAdel);
        exp_t e;
        e.pc   = ePc;
        e.lost = eLost;
        e.adel = eAdel;
        expQ.push_back(e);
        tagQ.push_back(tag);
    endtask

    // Advance one edge, then compare DUT outputs with the oldest expectation.
    task automatic tick();
        exp_t  e;
        string t;
        @(posedge clk);
        #1;
        checks++;
        assert (expQ.size() > 0) else begin
            errors++;
            $error("FAIL scoreboard_empty got %0d entries exp >0", expQ.size());
        end
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            t = tagQ.pop_front();
            checks++;
            assert (pc === e.pc) else begin
                errors++;
                $error("FAIL %s pc got %h exp %h", t, pc, e.pc);
            end
            checks++;
            assert (redirect_lost === e.lost) else begin
                errors++;
                $error("FAIL %s redirect_lost got %b exp %b", t, redirect_lost, e.lost);
            end
            checks++;
            assert (pc_adel === e.adel) else begin
                errors++;
                $error("FAIL %s pc_adel got %b exp %b", t, pc_adel, e.adel);
            end
        end
    endtask

    task automatic idle_inputs();
        stall    = 1'b0;
        br_taken = 1'b0;
        j_en     = 1'b0;
        jr_en    = 1'b0;
        exc_req  = 1'b0;
        eret_req = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        idle_inputs();
        br_offset = 32'h0;
        j_index   = 26'h0;
        jr_addr   = 32'h0;
        d_pc      = 32'h0;
        epc       = 32'h0;

        // Reset held two edges with a branch asserted.
        br_taken = 1'b1;
        expect_next("reset0", 32'h3000, 1'b0, 1'b0); tick();
        expect_next("reset1", 32'h3000, 1'b0, 1'b0); tick();
        reset    = 1'b1;
        br_taken = 1'b0;
        expect_next("seq1", 32'h3004, 1'b0, 1'b0); tick();
        expect_next("seq2", 32'h3008, 1'b0, 1'b0); tick();

        // Backward branch from d_pc.
        d_pc      = 32'h3010;
        br_offset = 32'hFFFF_FFFE;
        br_taken  = 1'b1;
        expect_next("branch", 32'h300C, 1'b0, 1'b0); tick();
        // Jump beats branch.
        j_en    = 1'b1;
        j_index = 26'h0000C40;
        expect_next("jump_over_br", 32'h3100, 1'b0, 1'b0); tick();
        idle_inputs();

        // Stall with one redirect buffered.
        stall   = 1'b1;
        jr_en   = 1'b1;
        jr_addr = 32'h3200;
        expect_next("stall1", 32'h3100, 1'b0, 1'b0); tick();
        jr_en = 1'b0;
        expect_next("stall2", 32'h3100, 1'b0, 1'b0); tick();
        expect_next("stall3", 32'h3100, 1'b0, 1'b0); tick();
        stall = 1'b0;
        expect_next("pend_drain", 32'h3200, 1'b0, 1'b0); tick();
        expect_next("pend_after", 32'h3204, 1'b0, 1'b0); tick();

        // Lost redirect.
        stall   = 1'b1;
        jr_en   = 1'b1;
        jr_addr = 32'h3200;
        expect_next("lost_stall", 32'h3204, 1'b0, 1'b0); tick();
        stall     = 1'b0;
        jr_en     = 1'b0;
        d_pc      = 32'h3000;
        br_offset = 32'h0000_00FF;
        br_taken  = 1'b1;
        expect_next("lost_pulse", 32'h3200, 1'b1, 1'b0); tick();
        br_taken = 1'b0;
        expect_next("lost_clear", 32'h3204, 1'b0, 1'b0); tick();
        expect_next("lost_stay0", 32'h3208, 1'b0, 1'b0); tick();

        // Exception over stall and pending, with eret also asserted.
        stall   = 1'b1;
        jr_en   = 1'b1;
        jr_addr = 32'h3300;
        expect_next("exc_pend", 32'h3208, 1'b0, 1'b0); tick();
        jr_en    = 1'b0;
        exc_req  = 1'b1;
        eret_req = 1'b1;
        expect_next("exc_wins", 32'h4180, 1'b0, 1'b0); tick();
        exc_req  = 1'b0;
        eret_req = 1'b0;
        expect_next("exc_hold", 32'h4180, 1'b0, 1'b0); tick();
        stall = 1'b0;
        expect_next("exc_pend_clr", 32'h4184, 1'b0, 1'b0); tick();
        eret_req = 1'b1;
        epc      = 32'h3018;
        expect_next("eret", 32'h3018, 1'b0, 1'b0); tick();
        eret_req = 1'b0;

        // jr beats j.
        jr_en   = 1'b1;
        j_en    = 1'b1;
        jr_addr = 32'h3500;
        expect_next("jr_over_j", 32'h3500, 1'b0, 1'b0); tick();
        j_en = 1'b0;

        // Address checking.
        jr_addr = 32'h3002;
        expect_next("adel_misalign", 32'h3002, 1'b0, 1'b1); tick();
        jr_addr = 32'h7000;
        expect_next("adel_above", 32'h7000, 1'b0, 1'b1); tick();
        jr_addr = 32'h6ffc;
        expect_next("adel_hi_edge", 32'h6ffc, 1'b0, 1'b0); tick();
        jr_addr = 32'h2ffc;
        expect_next("adel_below", 32'h2ffc, 1'b0, 1'b1); tick();
        jr_en = 1'b0;
        expect_next("adel_lo_edge", 32'h3000, 1'b0, 1'b0); tick();

        // Wrap past 2^32.
        jr_en   = 1'b1;
        jr_addr = 32'hFFFF_FFFC;
        expect_next("wrap_top", 32'hFFFF_FFFC, 1'b0, 1'b1); tick();
        jr_en = 1'b0;
        expect_next("wrap_zero", 32'h0000_0000, 1'b0, 1'b1); tick();

        // Reset during stall with a pending redirect clears the pending entry.
        stall   = 1'b1;
        jr_en   = 1'b1;
        jr_addr = 32'h5000;
        expect_next("rst_pend", 32'h0000_0000, 1'b0, 1'b1); tick();
        jr_en = 1'b0;
        reset = 1'b0;
        expect_next("rst_mid_stall", 32'h3000, 1'b0, 1'b0); tick();
        reset = 1'b1;
        stall = 1'b0;
        expect_next("rst_pend_clr", 32'h3004, 1'b0, 1'b0); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout got running exp finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
